mt9v032_word_align: RTL and testbench
=====================================

# mt9v032_word_align

Word-alignment and sync-decode stage for one MT9V032 LVDS channel, in the pixel `clk` domain directly downstream of `mt9v032_serdes`. It takes the unaligned 12-bit parallel word the deserializer delivers once per pixel clock and locates the start/stop-bit framing. It then emits aligned 10-bit pixels and decodes the embedded frame/line sync markers. One instance per sensor channel.

## Interface
- `LOCK_COUNT`, 64: consecutive good framings needed to declare lock (2..1024).
- `ERR_LIMIT`, 4: consecutive framing errors while locked that force re-search (1..16).
- `clk` in 1: pixel clock (`clk` from the clock generator).
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `in_valid` in 1: `in_data` is a new deserialized word.
- `in_data` in 12: raw word; bit 11 is the earliest received bit.
- `out_valid` out 1: `out_data` holds an aligned pixel.
- `out_data` out 10: pixel value.
- `out_fs`, `out_fe`, `out_ls`, `out_le` out 1 each: frame start, frame end, line start, line end flags.
- `locked` out 1: alignment established.
- `offset` out 4: current bit offset, 0..11.

## Operation
- Concatenate `{prev, in_data}`, 24 bits. `prev` is the last valid word; reset value 0.
- Window at offset k is bits [23-k : 12-k].
- Framing is good when window bit 11 = 1 (start bit) and bit 0 = 0 (stop bit).
- Pixel bits are sent LSB first: pixel[i] = window[10-i].
- All state advances only on `in_valid`. Cycles without it hold every register.
- SEARCH state:
  - Good framing: `good_cnt`++.
  - Bad framing: `good_cnt` = 0 and `offset` = (offset==11) ? 0 : offset+1.
  - When `good_cnt` reaches LOCK_COUNT (that word included): go to LOCKED and clear `err_cnt`.
- LOCKED state:
  - Good framing: `err_cnt` = 0.
  - Bad framing: `err_cnt`++.
  - When `err_cnt` reaches ERR_LIMIT: go to SEARCH, clear `good_cnt`, offset+1 with wrap, clear the sync history.
  - Every word in LOCKED is emitted, including bad-framing words with data as decoded. Only the words in LOCKED are emitted.
- Sync markers: 0 and 1023 are never image pixels. A marker is three consecutive emitted words 1023, 0, X:
  - X=1023: FS
  - X=1022: FE
  - X=0: LS
  - X=1: LE
- The matching flag is asserted with the third word. Marker words are still emitted with `out_valid`.
- Sync history is a 2-word shift of emitted pixels. It is cleared on reset and on leaving LOCKED.

## Timing
- Reset values:
  - `out_valid`, all sync flags, and `locked` are 0.
  - `out_data` is 0 and `offset` is 0.
  - State is SEARCH; `good_cnt`, `err_cnt`, and `prev` are 0.
- Latency: a word accepted on cycle n appears on `out_*` in cycle n+1, registered.
- `out_valid` and the flags are single-cycle pulses.
- `locked` rises in the cycle after the LOCK_COUNT-th good word, and that word itself is emitted.
- `locked` falls in the cycle after the ERR_LIMIT-th error, and that word is not emitted.
- Offset changes apply to the next accepted word.
- `rst` asserted mid-operation returns everything to reset values on the next edge. No output is produced for words presented during reset.

## Structure
- A shared package holds:
  - the sync constants `SYNC_HI`=1023, `SYNC_LO`=0, `CODE_FS`=1023, `CODE_FE`=1022, `CODE_LS`=0, `CODE_LE`=1;
  - the state encoding SEARCH/LOCKED.
- Sub-module `mt9v032_sync_decode`: the 2-word history plus the flag compare, fed by the emitted pixel stream.

## Test plan
- Stream framed pixels at true offset 5 after reset:
  - `offset` steps 0→5, one step per bad word.
  - `locked` rises after 64 good words.
  - The first emitted pixel equals the 64th sent pixel.
- Sequence at lock, pixels 100, 1023, 0, 1023, 200:
  - `out_fs` pulses with the third marker word only.
  - `out_data` sequence is unchanged.
- Markers 1023,0,1022 / 1023,0,0 / 1023,0,1:
  - `out_fe`, `out_ls`, `out_le` pulse respectively.
- While locked, inject 3 bad framings, then a good word, then 3 more bad:
  - `locked` stays 1.
  - Then inject 4 consecutive bad: `locked` falls, `offset` increments by 1, and re-lock occurs.
- True offset 11 starting from offset 11 with `in_valid` gaps of 1–3 cycles:
  - Lock after exactly 64 valid words.
  - No state change on idle cycles.
- Assert `rst` for one cycle while locked mid-line:
  - All outputs are 0 on the next cycle and `offset` is 0.
  - A partial marker pending before reset produces no flag.

Source files
------------

// File: rtl/mt9v032_word_align_pkg.sv
// Shared constants and types for the MT9V032 word-alignment stage.
package mt9v032_word_align_pkg;

    localparam int WORD_W     = 12;
    localparam int PIX_W      = 10;
    localparam int OFFSET_MAX = 11;

    // Embedded sync marker: SYNC_HI, SYNC_LO, then one of the codes below.
    localparam logic [PIX_W-1:0] SYNC_HI = 10'd1023;
    localparam logic [PIX_W-1:0] SYNC_LO = 10'd0;
    localparam logic [PIX_W-1:0] CODE_FS = 10'd1023;
    localparam logic [PIX_W-1:0] CODE_FE = 10'd1022;
    localparam logic [PIX_W-1:0] CODE_LS = 10'd0;
    localparam logic [PIX_W-1:0] CODE_LE = 10'd1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // Bit offset advance with wrap back to 0 after the last position.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'(OFFSET_MAX)) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/mt9v032_sync_decode.sv
// Sync marker decoder: two-word history of emitted pixels plus code compare.
// Flags are registered so they line up with the registered pixel output.
module mt9v032_sync_decode
    import mt9v032_word_align_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix,
    output logic             fs,
    output logic             fe,
    output logic             ls,
    output logic             le
);

    logic [PIX_W-1:0] hist_old;
    logic [PIX_W-1:0] hist_new;
    logic             marker_head;

    // The two previously emitted words form the SYNC_HI, SYNC_LO preamble.
    always_comb begin
        marker_head = (hist_old == SYNC_HI) && (hist_new == SYNC_LO);
    end

    // Shift history on each emitted pixel and pulse the matching flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist_old <= '0;
            hist_new <= '0;
            fs       <= 1'b0;
            fe       <= 1'b0;
            ls       <= 1'b0;
            le       <= 1'b0;
        end else begin
            fs <= 1'b0;
            fe <= 1'b0;
            ls <= 1'b0;
            le <= 1'b0;
            if (pix_valid) begin
                fs       <= marker_head && (pix == CODE_FS);
                fe       <= marker_head && (pix == CODE_FE);
                ls       <= marker_head && (pix == CODE_LS);
                le       <= marker_head && (pix == CODE_LE);
                hist_old <= hist_new;
                hist_new <= pix;
            end
        end
    end

endmodule

// File: rtl/mt9v032_word_align.sv
// Word alignment and sync decode for one MT9V032 LVDS channel.
// Searches the 12 bit offsets for start/stop framing, locks after a run of
// good words, emits bit-reversed 10-bit pixels while locked and drops back
// to search after a run of framing errors.
module mt9v032_word_align
    import mt9v032_word_align_pkg::*;
#(
    parameter int LOCK_COUNT = 64,
    parameter int ERR_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_fs,
    output logic              out_fe,
    output logic              out_ls,
    output logic              out_le,
    output logic              locked,
    output logic [3:0]        offset
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

    align_state_t        state;
    logic [WORD_W-1:0]   prev;
    logic [GOOD_W-1:0]   good_cnt;
    logic [ERR_W-1:0]    err_cnt;

    logic [2*WORD_W-1:0] joined;
    logic [WORD_W-1:0]   window;
    logic [PIX_W-1:0]    pixel;
    logic                framing_good;
    logic [GOOD_W-1:0]   good_next;
    logic [ERR_W-1:0]    err_next;
    logic                lock_hit;
    logic                drop_hit;
    logic                emit;
    logic                sync_clear;

    // Extract the 12-bit window at the current offset and unpack the pixel.
    always_comb begin
        joined       = {prev, in_data};
        window       = joined[5'd23 - {1'b0, offset} -: WORD_W];
        framing_good = window[WORD_W-1] & ~window[0];
        pixel        = '0;
        for (int unsigned i = 0; i < PIX_W; i++) begin
            pixel[i] = window[PIX_W - i];
        end
    end

    // Lock/unlock decisions and emit qualification for the current word.
    always_comb begin
        good_next  = good_cnt + 1'b1;
        err_next   = err_cnt + 1'b1;
        lock_hit   = framing_good && (good_next == GOOD_W'(LOCK_COUNT));
        drop_hit   = !framing_good && (err_next == ERR_W'(ERR_LIMIT));
        emit       = in_valid && (((state == SEARCH) && lock_hit) ||
                                  ((state == LOCKED) && !drop_hit));
        sync_clear = in_valid && (state == LOCKED) && drop_hit;
    end

    // Alignment FSM with registered pixel and lock outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            offset    <= '0;
            prev      <= '0;
            good_cnt  <= '0;
            err_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_data <= pixel;
            end
            if (in_valid) begin
                prev <= in_data;
                case (state)
                    SEARCH: begin
                        if (framing_good) begin
                            if (lock_hit) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                                err_cnt  <= '0;
                            end else begin
                                good_cnt <= good_next;
                            end
                        end else begin
                            good_cnt <= '0;
                            offset   <= next_offset(offset);
                        end
                    end
                    LOCKED: begin
                        if (framing_good) begin
                            err_cnt <= '0;
                        end else if (drop_hit) begin
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            err_cnt  <= '0;
                            offset   <= next_offset(offset);
                        end else begin
                            err_cnt <= err_next;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    mt9v032_sync_decode u_sync (
        .clk       (clk),
        .rst       (rst),
        .clear     (sync_clear),
        .pix_valid (emit),
        .pix       (pixel),
        .fs        (out_fs),
        .fe        (out_fe),
        .ls        (out_ls),
        .le        (out_le)
    );

endmodule

// File: tb/tb_mt9v032_word_align.sv
// Self-checking bench for mt9v032_word_align: serial frame generator at a
// chosen true bit offset, reference model built from the framing rules,
// table-driven sync marker vectors and directed lock/unlock/reset sequences.
module tb_mt9v032_word_align;

    localparam int LOCK_N = 64;
    localparam int ERR_N  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        out_fs, out_fe, out_ls, out_le;
    logic        locked;
    logic [3:0]  offset;

    always #5 clk = ~clk;

    mt9v032_word_align #(
        .LOCK_COUNT (LOCK_N),
        .ERR_LIMIT  (ERR_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_fs    (out_fs),
        .out_fe    (out_fe),
        .out_ls    (out_ls),
        .out_le    (out_le),
        .locked    (locked),
        .offset    (offset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_lock;
    int m_off, m_good, m_err, m_prev;
    int hist[$];
    bit e_valid, e_fs, e_fe, e_ls, e_le;
    int e_data;

    // Frame generator state
    logic [11:0] last_frame;
    int true_k;
    int sent_prev, sent_last;

    typedef struct {
        int pix;
        bit fs, fe, ls, le;
    } vec_t;
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode_pix(input int win);
        int p = 0;
        for (int i = 0; i < 10; i++) begin
            if (((win >> (10 - i)) & 1) == 1) p += (1 << i);
        end
        return p;
    endfunction

    function automatic int rand_pix();
        return int'($urandom_range(1021, 2));
    endfunction

    task automatic model_step(input bit r, input bit v, input int d);
        int  cat, win, pix;
        bit  good, emit;
        e_valid = 0; e_fs = 0; e_fe = 0; e_ls = 0; e_le = 0;
        if (r) begin
            m_lock = 0; m_off = 0; m_good = 0; m_err = 0; m_prev = 0;
            e_data = 0;
            hist.delete();
            return;
        end
        if (!v) return;
        cat    = m_prev * 4096 + d;
        win    = (cat >> (12 - m_off)) % 4096;
        good   = (((win >> 11) & 1) == 1) && ((win & 1) == 0);
        pix    = decode_pix(win);
        m_prev = d;
        emit   = 0;
        if (!m_lock) begin
            if (good) begin
                m_good++;
                if (m_good == LOCK_N) begin
                    m_lock = 1; m_err = 0; emit = 1;
                end
            end else begin
                m_good = 0;
                m_off  = (m_off + 1) % 12;
            end
        end else begin
            if (good) m_err = 0;
            else m_err++;
            if (m_err == ERR_N) begin
                m_lock = 0; m_good = 0; m_err = 0;
                m_off  = (m_off + 1) % 12;
                hist.delete();
            end else begin
                emit = 1;
            end
        end
        if (emit) begin
            e_valid = 1;
            e_data  = pix;
            hist.push_back(pix);
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3 && hist[0] == 1023 && hist[1] == 0) begin
                e_fs = (pix == 1023);
                e_fe = (pix == 1022);
                e_ls = (pix == 0);
                e_le = (pix == 1);
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [11:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step(r, v, int'(d));
        #1;
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("locked",    32'(locked),    32'(m_lock));
        check("offset",    32'(offset),    32'(m_off));
        check("out_fs",    32'(out_fs),    32'(e_fs));
        check("out_fe",    32'(out_fe),    32'(e_fe));
        check("out_ls",    32'(out_ls),    32'(e_ls));
        check("out_le",    32'(out_le),    32'(e_le));
        if (e_valid) check("out_data", 32'(out_data), 32'(e_data));
    endtask

    function automatic logic [11:0] make_frame(input int p, input bit bad);
        logic [11:0] f;
        logic [9:0]  pv;
        pv    = 10'(p);
        f[11] = ~bad;
        f[0]  = 1'b0;
        for (int i = 0; i < 10; i++) f[10 - i] = pv[i];
        return f;
    endfunction

    task automatic send_frame(input int p, input bit bad);
        logic [11:0] fr;
        logic [23:0] c;
        fr         = make_frame(p, bad);
        c          = {last_frame, fr} >> true_k;
        last_frame = fr;
        sent_prev  = sent_last;
        sent_last  = p;
        step(1'b0, 1'b1, c[11:0]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  got;
        int  off_b;
        bit  lk_b;
        bit  bad_pat[13];

        tbl[0]  = '{100,  0, 0, 0, 0};
        tbl[1]  = '{1023, 0, 0, 0, 0};
        tbl[2]  = '{0,    0, 0, 0, 0};
        tbl[3]  = '{1023, 1, 0, 0, 0};
        tbl[4]  = '{200,  0, 0, 0, 0};
        tbl[5]  = '{1023, 0, 0, 0, 0};
        tbl[6]  = '{0,    0, 0, 0, 0};
        tbl[7]  = '{1022, 0, 1, 0, 0};
        tbl[8]  = '{1023, 0, 0, 0, 0};
        tbl[9]  = '{0,    0, 0, 0, 0};
        tbl[10] = '{0,    0, 0, 1, 0};
        tbl[11] = '{1023, 0, 0, 0, 0};
        tbl[12] = '{0,    0, 0, 0, 0};
        tbl[13] = '{1,    0, 0, 0, 1};
        tbl[14] = '{300,  0, 0, 0, 0};
        bad_pat = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        last_frame = '0; sent_prev = 0; sent_last = 0;

        // Reset, including a word presented while in reset
        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, 12'hABC);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset offset",   32'(offset),   32'd0);
        check("reset locked",   32'(locked),   32'd0);
        check("reset valid",    32'(out_valid), 32'd0);

        // Lock at true offset 5
        true_k = 5; cnt = 0; got = 0;
        for (int w = 0; w < 300 && !got; w++) begin
            off_b = int'(offset); lk_b = locked;
            send_frame(rand_pix(), 1'b0);
            if (!lk_b && off_b == 5) cnt++;
            if (locked) got = 1;
        end
        check("lock1 reached",   32'(got), 32'd1);
        check("lock1 good run",  32'(cnt), 32'(LOCK_N));
        check("lock1 offset",    32'(offset), 32'd5);
        check("lock1 emit",      32'(out_valid), 32'd1);
        check("lock1 first pix", 32'(out_data), 32'(sent_prev));

        // Sync marker table; each output lags its input word by one
        for (int i = 0; i < 16; i++) begin
            send_frame((i < 15) ? tbl[i].pix : rand_pix(), 1'b0);
            if (i > 0) begin
                check("tbl valid", 32'(out_valid), 32'd1);
                check("tbl data",  32'(out_data),  32'(tbl[i-1].pix));
                check("tbl fs",    32'(out_fs),    32'(tbl[i-1].fs));
                check("tbl fe",    32'(out_fe),    32'(tbl[i-1].fe));
                check("tbl ls",    32'(out_ls),    32'(tbl[i-1].ls));
                check("tbl le",    32'(out_le),    32'(tbl[i-1].le));
            end
        end

        // Error tolerance and loss of lock
        for (int i = 0; i < 13; i++) begin
            send_frame(rand_pix(), bad_pat[i]);
            if (i == 7 || i == 11) check("lock held", 32'(locked), 32'd1);
            if (i == 12) begin
                check("lock lost",        32'(locked),    32'd0);
                check("lock lost offset", 32'(offset),    32'd6);
                check("lock lost emit",   32'(out_valid), 32'd0);
            end
        end
        got = 0;
        for (int w = 0; w < 400 && !got; w++) begin
            send_frame(rand_pix(), 1'b0);
            if (locked) got = 1;
        end
        check("relock reached", 32'(got), 32'd1);
        check("relock offset",  32'(offset), 32'd5);

        // True offset 11 with idle gaps
        step(1'b1, 1'b0, 12'h000);
        last_frame = '0; true_k = 11;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 12'h000);
        check("pre-offset", 32'(offset), 32'd10);
        cnt = 0; got = 0;
        for (int w = 0; w < 400 && !got; w++) begin
            off_b = int'(offset); lk_b = locked;
            send_frame(rand_pix(), 1'b0);
            if (!lk_b && off_b == 11) cnt++;
            if (locked) got = 1;
            else begin
                repeat ($urandom_range(3, 1)) step(1'b0, 1'b0, 12'($urandom));
            end
        end
        check("lock11 reached",  32'(got), 32'd1);
        check("lock11 good run", 32'(cnt), 32'(LOCK_N));
        check("lock11 offset",   32'(offset), 32'd11);

        // Reset while a partial marker is pending
        send_frame(1023, 1'b0);
        send_frame(0, 1'b0);
        send_frame(rand_pix(), 1'b0);
        step(1'b1, 1'b1, 12'($urandom));
        check("mid rst valid",  32'(out_valid), 32'd0);
        check("mid rst data",   32'(out_data),  32'd0);
        check("mid rst offset", 32'(offset),    32'd0);
        check("mid rst locked", 32'(locked),    32'd0);
        check("mid rst flags",  32'({out_fs, out_fe, out_ls, out_le}), 32'd0);
        got = 0;
        for (int w = 0; w < 300 && !got; w++) begin
            send_frame(1023, 1'b0);
            if (locked) got = 1;
        end
        check("post rst lock",  32'(got), 32'd1);
        check("post rst pix",   32'(out_data), 32'd1023);
        check("post rst no fs", 32'(out_fs), 32'd0);
        for (int i = 0; i < 3; i++) send_frame(1023, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
